// File: rtl/prg_shift_out_if.sv
// Word handshake between a parallel (addr, data) source and the serial program loader.
interface prg_shift_out_if;
   logic       word_valid;
   logic       word_ready;
   logic [7:0] word_addr;
   logic [7:0] word_data;

   modport master (output word_valid, word_addr, word_data, input word_ready);
   modport slave  (input word_valid, word_addr, word_data, output word_ready);
endinterface

// File: rtl/prg_shift_out.sv
// Serial program-loader transmitter: shifts {addr, data} MSB-first on din/shift_clk,
// then pulses latch so the target's 16-bit shift-in port writes one code-RAM byte.
module prg_shift_out #(
   parameter int DIV          = 4,
   parameter int LATCH_CYCLES = 2
) (
   input  logic           clk,
   input  logic           nreset,
   prg_shift_out_if.slave wif,
   output logic           prg_din,
   output logic           prg_shift_clk,
   output logic           prg_latch,
   output logic           busy
);
   typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_TAIL, S_LATCH} state_t;

   localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
   localparam logic [7:0] LAT_M1 = 8'(LATCH_CYCLES - 1);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [3:0]  r_idx, w_idx_nxt;
   logic [15:0] r_sr, w_sr_nxt;
   logic        r_ready, r_busy, r_din, r_sclk, r_latch;
   logic        w_ready_nxt, w_busy_nxt, w_din_nxt, w_sclk_nxt, w_latch_nxt;
   logic        w_accept;

   assign w_accept = wif.word_valid & r_ready;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_sr    <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_din   <= 1'b0;
         r_sclk  <= 1'b0;
         r_latch <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_sr    <= w_sr_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
         r_din   <= w_din_nxt;
         r_sclk  <= w_sclk_nxt;
         r_latch <= w_latch_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_sr_nxt    = r_sr;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_LO;
               w_cnt_nxt   = DIV_M1;
               w_idx_nxt   = 4'd15;
               w_sr_nxt    = {wif.word_addr, wif.word_data};
            end
         end
         S_LO: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = S_HI;
               w_cnt_nxt   = DIV_M1;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_HI: begin
            if (r_cnt == 8'd0) begin
               w_cnt_nxt = DIV_M1;
               if (r_idx == 4'd0) begin
                  w_state_nxt = S_TAIL;
               end else begin
                  w_state_nxt = S_LO;
                  w_idx_nxt   = r_idx - 4'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_TAIL: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = S_LATCH;
               w_cnt_nxt   = LAT_M1;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_LATCH: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      w_ready_nxt = (w_state_nxt == S_IDLE);
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_sclk_nxt  = (w_state_nxt == S_HI);
      w_latch_nxt = (w_state_nxt == S_LATCH);
      w_din_nxt   = (w_state_nxt == S_IDLE) ? 1'b0 : w_sr_nxt[w_idx_nxt];
   end

   assign wif.word_ready = r_ready;
   assign busy           = r_busy;
   assign prg_din        = r_din;
   assign prg_shift_clk  = r_sclk;
   assign prg_latch      = r_latch;
endmodule
